// File: rtl/int_divider.sv
// rtl/int_divider.sv - iterative signed restoring divider, one quotient bit per clock
module int_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   prem;
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg;
   logic             accept, take, divisor_zero, trial_ok;
   logic [WIDTH+1:0] shifted, trial;
   logic [WIDTH-1:0] dividend_abs, divisor_abs;

   assign in_ready     = (state == IDLE);
   assign accept       = in_valid && in_ready;
   assign take         = out_valid && out_ready;
   assign divisor_zero = (divisor == '0);
   assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

   // One spare top bit makes the trial difference's sign unambiguous
   assign shifted  = {prem, dvd[WIDTH-1]};
   assign trial    = shifted - {2'b00, dvs};
   assign trial_ok = ~trial[WIDTH+1];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = divisor_zero ? DONE : CALC;
         CALC: if (cnt == '0) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: if (take) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd         <= '0;
         dvs         <= '0;
         prem        <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd         <= dividend_abs;
                  dvs         <= divisor_abs;
                  q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg       <= dividend[WIDTH-1];
                  prem        <= '0;
                  cnt         <= CW'(WIDTH - 1);
                  div_by_zero <= divisor_zero;
                  overflow    <= 1'b0;
                  if (divisor_zero) begin
                     quotient  <= {dividend[WIDTH-1], {(WIDTH-1){~dividend[WIDTH-1]}}};
                     remainder <= dividend;
                  end
               end
            end
            CALC: begin
               prem <= trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
               dvd  <= {dvd[WIDTH-2:0], trial_ok};
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            FIX: begin
               // A positive quotient with its MSB set is only reachable from MIN / -1
               if (!q_neg && dvd[WIDTH-1]) begin
                  quotient  <= {1'b0, {(WIDTH-1){1'b1}}};
                  remainder <= '0;
                  overflow  <= 1'b1;
               end else begin
                  quotient  <= q_neg ? -dvd : dvd;
                  remainder <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
               end
            end
            DONE: out_valid <= !take;
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_int_divider.sv
// tb/tb_int_divider.sv - scoreboard bench for int_divider with directed vectors
module tb_int_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   int_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every completed handshake pops one expected result
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input logic eovf,
                         input int elat, input int hold);
      exp_t e;
      int   k;
      logic busy_ready;
      logic [31:0] cq, cr;
      logic cd, co;
      e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
      sb.push_back(e);
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 200);
      if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy_ready = 1'b0;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
         if (in_ready) busy_ready = 1'b1;
      end while (!out_valid && k < 100);
      chk("latency", k, elat);
      chk("in_ready_busy", {31'd0, busy_ready}, 32'd0);
      if (hold > 0) begin
         cq = quotient; cr = remainder; cd = div_by_zero; co = overflow;
         busy_ready = 1'b0;
         // A competing request during backpressure must not be taken
         dividend = 32'd21; divisor = 32'd4; in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (in_ready || !out_valid || quotient !== cq || remainder !== cr ||
                div_by_zero !== cd || overflow !== co) busy_ready = 1'b1;
         end
         chk("hold_stable", {31'd0, busy_ready}, 32'd0);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("out_valid_after", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);
      run_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0, 34, 0);
      run_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0, 34, 0);
      run_op(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 1'b0, 34, 0);
      run_op(32'h80000000, 32'd2, 32'hC0000000, 32'd0, 1'b0, 1'b0, 34, 0);
      run_op(32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b1, 34, 0);
      run_op(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 1'b0, 34, 0);
      run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 34, 0);
      run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 34, 0);
      run_op(32'd5, 32'd0, 32'h7FFFFFFF, 32'd5, 1'b1, 1'b0, 1, 0);
      run_op(-32'sd5, 32'd0, 32'h80000000, -32'sd5, 1'b1, 1'b0, 1, 0);
      run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34, 10);
      run_op(32'd21, 32'd4, 32'd5, 32'd1, 1'b0, 1'b0, 34, 0);

      // Abort an operation mid-CALC; it must never produce a result
      dividend = 32'd12345; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 34, 0);

      repeat (40) @(posedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
